piso_stream: RTL

//  Parametrised parallel-in/serial-out serializer with a valid/ready load handshake.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_tick.sv | 38 +++
 rtl/piso_stream.sv | 98 +++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
package piso_pkg;

  // Serializer FSM encoding: idle waiting for a word, or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width helper: a counter over n values still needs at least one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_tick.sv
// Bit-period divider: counts DIV clocks per serial bit and flags the last one.
module piso_bit_tick
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int DW = clog2_min1(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Count clocks within a bit; wrap on the final clock so each bit restarts at 0.
  always_ff @(posedge clk) begin
    if (clear || bit_tick)
      div_cnt <= '0;
    else if (enable)
      div_cnt <= div_cnt + DW'(1);
  end

  // pre_tick marks the clock before bit_tick, letting the top register frame_done.
  generate
    if (DIV == 1) begin : g_div1
      assign bit_tick = 1'b1;
      assign pre_tick = 1'b1;
    end else begin : g_divn
      assign bit_tick = (div_cnt == LAST);
      assign pre_tick = (div_cnt == LAST - DW'(1));
    end
  endgenerate

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a valid/ready load handshake.
// State | meaning
// IDLE  | line at IDLE_LEVEL, ready for a word
// SHIFT | word in flight, one bit every DIV clocks
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int DIV        = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = clog2_min1(WIDTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] PENULT_BIT = BW'(WIDTH - 2);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             serial_out_d, frame_done_d;
  logic             bit_tick, pre_tick, last_win, accept;

  // The bit currently presented sits at the head of the shift register.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign last_win     = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT) && bit_tick;
  assign load_ready   = (state_q == ST_IDLE) || last_win;
  assign accept       = load_valid && load_ready;
  assign busy         = (state_q == ST_SHIFT);
  assign serial_valid = (state_q == ST_SHIFT);

  piso_bit_tick #(.DIV(DIV)) u_bit_tick (
    .clk      (clk),
    .clear    (reset || accept),
    .enable   (state_q == ST_SHIFT),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  // Next state, shift register and registered-output precompute.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (accept) begin
      state_d   = ST_SHIFT;
      sreg_d    = parallel_in;
      bit_cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      if (last_win) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end else begin
        // Raise frame_done one clock early so the flop lands on the last-bit window.
        frame_done_d = pre_tick && (bit_tick ? (bit_cnt_q == PENULT_BIT)
                                             : (bit_cnt_q == LAST_BIT));
        if (bit_tick) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          sreg_d    = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
        end
      end
    end
    serial_out_d = (state_d == ST_SHIFT) ? head(sreg_d) : IDLE_BIT;
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      serial_out <= IDLE_BIT;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      serial_out <= serial_out_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
